if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 65 ++++++
 rtl/if_stage.sv | 132 +++++++++++++
 tb/tb_if_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_pkg
//  Brief    : Shared constants and fetch-entry type for the instruction fetch
//             stage.
//  Revision : 1.0  initial release
// ============================================================================
package if_stage_pkg;

  // Instruction width of the base ISA.
  localparam int ILEN = 32;

  // Default first fetch address after reset.
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

  // Default-XLEN (64-bit) view of one fetch-queue entry: PC plus instruction.
  typedef struct packed {
    logic [63:0]     pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Brief    : Synchronous FIFO with push, pop, flush and occupancy count.
//             DEPTH must be a power of two >= 2 so pointers wrap naturally.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_do_push;
  logic             w_do_pop;

  // Overflowing pushes and underflowing pops are ignored.
  assign w_do_push = push_i && (count_q != C_FULL);
  assign w_do_pop  = pop_i  && (count_q != '0);

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  // Pointer and count update; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Brief    : Instruction fetch stage. Issues in-order word fetches under a
//             credit rule, queues returned instructions with their PCs and
//             discards responses belonging to requests issued before a
//             redirect.
//  Revision : 1.0  initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC[XLEN-1:0],
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0] C_DEPTH = (CW+1)'(FQ_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q,  resp_pc_d;   // PC of the next kept response
  logic [CW-1:0]   outst_q,    outst_d;
  logic [CW-1:0]   drop_q,     drop_d;

  logic [CW-1:0]   w_q_count;
  logic            w_q_empty;
  entry_t          w_q_head;
  entry_t          w_push_entry;
  logic [CW:0]     w_credit_sum;
  logic [XLEN-1:0] w_redirect_aligned;
  logic            w_hs;
  logic            w_resp_ok;
  logic            w_push;
  logic            w_pop;

  // Outstanding requests count against queue space, so the queue cannot overflow.
  assign w_credit_sum       = {1'b0, w_q_count} + {1'b0, outst_q};
  assign w_redirect_aligned = redirect_pc & ~XLEN'(3);

  assign imem_req_valid = !rst && !redirect_valid && (w_credit_sum < C_DEPTH);
  assign imem_req_addr  = fetch_pc_q;
  assign w_hs           = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp_ok = !rst && imem_resp_valid && (outst_q != '0);
  assign w_push    = w_resp_ok && (drop_q == '0) && !redirect_valid;

  assign out_valid = !rst && !w_q_empty && !redirect_valid;
  assign w_pop     = out_valid && out_ready;
  assign out_inst  = (rst || w_q_empty) ? '0 : w_q_head.inst;
  assign out_pc    = (rst || w_q_empty) ? '0 : w_q_head.pc;

  assign w_push_entry.pc   = resp_pc_q;
  assign w_push_entry.inst = imem_resp_inst;

  // Next-state for PCs, in-flight count and the stale-response drop budget.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;

    case ({w_hs, w_resp_ok})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = w_redirect_aligned;
      resp_pc_d  = w_redirect_aligned;
      // Everything still in flight after this cycle belongs to the old path.
      drop_d     = outst_d;
    end else begin
      if (w_hs)   fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (w_push) resp_pc_d  = resp_pc_q + XLEN'(4);
      if (w_resp_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fetch_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .flush_i (redirect_valid),
    .data_o  (w_q_head),
    .count_o (w_q_count),
    .empty_o (w_q_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Brief    : Self-checking bench for if_stage: directed cycle table, wrap and
//             reset sequences, and a randomised scoreboard run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_inst = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [63:0] out_pc;

  always #5 clk = ~clk;

  if_stage #(.XLEN(64), .RESET_PC(RPC), .FQ_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rst, rr, rv;
    logic [31:0] inst;
    logic        rd;
    logic [63:0] rdpc;
    logic        ordy;
    logic        e_rv;
    logic [63:0] e_addr;
    logic        e_ov;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    int          due;
  } pend_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rs, input logic rr, input logic rv,
                              input logic [31:0] inst, input logic rd,
                              input logic [63:0] rdpc, input logic ordy,
                              input logic e_rv, input logic [63:0] e_addr,
                              input logic e_ov, input logic [63:0] e_pc,
                              input logic [31:0] e_inst);
    vec_t v;
    v.rst = rs; v.rr = rr; v.rv = rv; v.inst = inst; v.rd = rd; v.rdpc = rdpc;
    v.ordy = ordy; v.e_rv = e_rv; v.e_addr = e_addr; v.e_ov = e_ov;
    v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_A5A5;
  endfunction

  // One clock cycle: drive inputs after the edge, check outputs mid-cycle.
  task automatic apply_row(input vec_t r, input string tag);
    @(posedge clk); #1;
    rst = r.rst; imem_req_ready = r.rr; imem_resp_valid = r.rv;
    imem_resp_inst = r.inst; redirect_valid = r.rd; redirect_pc = r.rdpc;
    out_ready = r.ordy;
    @(negedge clk);
    check({tag, ".req_valid"}, 64'(imem_req_valid), 64'(r.e_rv));
    if (r.e_rv) check({tag, ".req_addr"}, imem_req_addr, r.e_addr);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(r.e_ov));
    if (r.e_ov || r.rst) begin
      check({tag, ".out_pc"},   out_pc,          r.e_pc);
      check({tag, ".out_inst"}, 64'(out_inst),   64'(r.e_inst));
    end
  endtask

  vec_t  tbl[$];
  pend_t pend[$];

  initial begin
    // rst rr rv inst  rd rdpc  ordy | e_rv e_addr  e_ov e_pc  e_inst
    tbl.push_back(mk(1,1,1,32'h1111_1111,0,0,1, 0,0,            0,0,0));
    tbl.push_back(mk(1,1,1,32'h1111_1111,0,0,1, 0,0,            0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,             1,64'h8000_0000,0,0,0));
    tbl.push_back(mk(0,1,1,32'hA000_0001,0,0,0, 1,64'h8000_0004,0,0,0));
    tbl.push_back(mk(0,1,1,32'hA000_0002,0,0,0, 1,64'h8000_0008,1,64'h8000_0000,32'hA000_0001));
    tbl.push_back(mk(0,1,0,0,0,0,0,             1,64'h8000_000C,1,64'h8000_0000,32'hA000_0001));
    tbl.push_back(mk(0,1,0,0,0,0,0,             0,0,            1,64'h8000_0000,32'hA000_0001));
    tbl.push_back(mk(0,1,1,32'hA000_0003,0,0,0, 0,0,            1,64'h8000_0000,32'hA000_0001));
    tbl.push_back(mk(0,1,1,32'hA000_0004,0,0,1, 0,0,            1,64'h8000_0000,32'hA000_0001));
    tbl.push_back(mk(0,0,0,0,0,0,1,             1,64'h8000_0010,1,64'h8000_0004,32'hA000_0002));
    tbl.push_back(mk(0,0,0,0,0,0,0,             1,64'h8000_0010,1,64'h8000_0008,32'hA000_0003));
    tbl.push_back(mk(0,1,0,0,0,0,0,             1,64'h8000_0010,1,64'h8000_0008,32'hA000_0003));
    tbl.push_back(mk(0,1,0,0,0,0,0,             1,64'h8000_0014,1,64'h8000_0008,32'hA000_0003));
    // redirect with two requests outstanding, queue flushed
    tbl.push_back(mk(0,1,0,0,1,64'h8000_1002,1, 0,0,            0,0,0));
    tbl.push_back(mk(0,1,1,32'hDEAD_0001,0,0,1, 1,64'h8000_1000,0,0,0));
    tbl.push_back(mk(0,0,1,32'hDEAD_0002,0,0,1, 1,64'h8000_1004,0,0,0));
    tbl.push_back(mk(0,0,1,32'hB000_0000,0,0,1, 1,64'h8000_1004,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,             1,64'h8000_1004,1,64'h8000_1000,32'hB000_0000));
    // response with nothing outstanding must be ignored
    tbl.push_back(mk(0,0,1,32'hEEEE_0000,0,0,1, 1,64'h8000_1004,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,             1,64'h8000_1004,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,1,             1,64'h8000_1004,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,1,             1,64'h8000_1008,0,0,0));
    // redirect with response in same cycle, then back-to-back redirect
    tbl.push_back(mk(0,1,1,32'hDEAD_0003,1,64'h8000_2000,1, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,1,64'h8000_3004,1, 0,0,            0,0,0));
    tbl.push_back(mk(0,1,1,32'hDEAD_0004,0,0,1, 1,64'h8000_3004,0,0,0));
    tbl.push_back(mk(0,0,1,32'hB000_0001,0,0,1, 1,64'h8000_3008,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,             1,64'h8000_3008,1,64'h8000_3004,32'hB000_0001));
    tbl.push_back(mk(0,0,0,0,0,0,1,             1,64'h8000_3008,0,0,0));

    foreach (tbl[i]) apply_row(tbl[i], $sformatf("row%0d", i));

    // Address wrap at the top of the address space, then a mid-stream reset.
    apply_row(mk(0,0,0,0,1,64'hFFFF_FFFF_FFFF_FFFF,0, 0,0,0,0,0), "wrap0");
    apply_row(mk(0,1,0,0,0,0,0, 1,64'hFFFF_FFFF_FFFF_FFFC,0,0,0), "wrap1");
    apply_row(mk(0,0,1,32'h1234_5678,0,0,0, 1,64'h0,0,0,0), "wrap2");
    apply_row(mk(0,0,0,0,0,0,0, 1,64'h0,1,64'hFFFF_FFFF_FFFF_FFFC,32'h1234_5678), "wrap3");
    apply_row(mk(1,1,0,0,0,0,0, 0,0,0,0,0), "rstmid");
    apply_row(mk(0,0,0,0,0,0,0, 1,RPC,0,0,0), "rstafter");

    // Randomised run against an in-order memory with 1-3 cycle latency.
    begin
      logic [63:0] exp_pc;
      int          pops;
      int          last_due;
      @(posedge clk); #1;
      rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
      redirect_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_pc   = RPC;
      pops     = 0;
      last_due = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        imem_req_ready = ($urandom_range(0, 3) != 0);
        out_ready      = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 39) == 0);
        redirect_pc    = {32'h0, $urandom};
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          imem_resp_valid = 1'b1;
          imem_resp_inst  = inst_of(pend[0].pc);
        end else begin
          imem_resp_valid = 1'b0;
        end
        @(negedge clk);
        if (redirect_valid) begin
          check("rnd.out_valid_on_redirect", 64'(out_valid), 64'd0);
          exp_pc = redirect_pc & ~64'h3;
        end else if (out_valid && out_ready) begin
          check("rnd.out_pc",   out_pc,        exp_pc);
          check("rnd.out_inst", 64'(out_inst), 64'(inst_of(exp_pc)));
          exp_pc = exp_pc + 64'd4;
          pops++;
        end
        if (imem_resp_valid) void'(pend.pop_front());
        if (imem_req_valid && imem_req_ready) begin
          pend_t p;
          int    lat;
          lat   = $urandom_range(1, 3);
          p.pc  = imem_req_addr;
          p.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
          last_due = p.due;
          pend.push_back(p);
          check("rnd.credit", 64'(pend.size() <= 4), 64'd1);
        end
        @(posedge clk); #1;
      end
      check("rnd.progress", 64'(pops > 200), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
